// File: rtl/mcu_mem_responder.sv
// ---------------------------------------------------------------------------
// mcu_mem_responder
//
// Memory-side responder for the main control unit. Read and write request
// pulses are latched into one pending slot each. A small FSM turns each
// pending request into a single ack-handshaked transaction on the external
// memory port, then pulses a one-cycle completion back to the control unit.
//
// Ports
//   clk, n_rst           : clock (rising edge), asynchronous active-low reset
//   i_re/i_raddr         : read request pulse and its address
//   i_we/i_waddr/i_wdata : write request pulse, address and data
//   o_read_complete      : one-cycle pulse, o_rdata valid in the same cycle
//   o_rdata              : last read data (0 after an errored read)
//   o_write_complete     : one-cycle pulse when a write finishes
//   o_err                : sticky error (range, timeout, slot overflow)
//   o_busy               : FSM not idle or any request pending
//   o_mem_*/i_mem_*      : external memory request/ack port
// ---------------------------------------------------------------------------
module mcu_mem_responder #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BASE  = 0,
    parameter int MEM_LIMIT = 760000,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_read_complete,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_write_complete,
    output logic              o_err,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_req,
    output logic              o_mem_wen,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DONE = 3'd2,
        WR_REQ  = 3'd3,
        WR_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_L    = ADDR_W'(MEM_BASE);
    localparam logic [ADDR_W-1:0] SPAN_L    = ADDR_W'(MEM_LIMIT - MEM_BASE);
    localparam logic [7:0]        TIMEOUT_L = TIMEOUT[7:0];

    state_t              state_q, state_d;
    logic                rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0]   cur_wdata_q, cur_wdata_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                rd_take, wr_take;
    logic [7:0]          cnt_inc;

    // Offset compare: an address below the base wraps to a huge offset and
    // fails the span test, so one unsigned compare covers both bounds.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a - BASE_L) < SPAN_L;
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cur_addr_q  <= '0;
            cur_wdata_q <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
            wr_pend_q   <= wr_pend_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cur_addr_q  <= cur_addr_d;
            cur_wdata_q <= cur_wdata_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_pend_d   = rd_pend_q;
        rd_addr_d   = rd_addr_q;
        wr_pend_d   = wr_pend_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        cur_addr_d  = cur_addr_q;
        cur_wdata_d = cur_wdata_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        rd_take     = 1'b0;
        wr_take     = 1'b0;
        cnt_inc     = cnt_q + 8'd1;

        case (state_q)
            IDLE: begin
                // Reads win: the control unit stalls until read data returns.
                // The active request is copied out so its slot can refill now.
                if (rd_pend_q) begin
                    rd_take    = 1'b1;
                    cur_addr_d = rd_addr_q;
                    if (in_range(rd_addr_q)) begin
                        state_d = RD_REQ;
                    end else begin
                        state_d = RD_DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end else if (wr_pend_q) begin
                    wr_take     = 1'b1;
                    cur_addr_d  = wr_addr_q;
                    cur_wdata_d = wr_data_q;
                    if (in_range(wr_addr_q)) begin
                        state_d = WR_REQ;
                    end else begin
                        state_d = WR_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (i_mem_ack) begin
                    rdata_d = i_mem_rdata;
                    state_d = RD_DONE;
                    cnt_d   = '0;
                end else if (cnt_inc == TIMEOUT_L) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RD_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WR_REQ: begin
                if (i_mem_ack) begin
                    state_d = WR_DONE;
                    cnt_d   = '0;
                end else if (cnt_inc == TIMEOUT_L) begin
                    err_d   = 1'b1;
                    state_d = WR_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RD_DONE: state_d = IDLE;
            WR_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Slot capture; a slot being drained this cycle counts as free.
        if (rd_take) begin
            rd_pend_d = 1'b0;
        end
        if (i_re) begin
            if (rd_pend_q && !rd_take) begin
                err_d = 1'b1;
            end else begin
                rd_pend_d = 1'b1;
                rd_addr_d = i_raddr;
            end
        end

        if (wr_take) begin
            wr_pend_d = 1'b0;
        end
        if (i_we) begin
            if (wr_pend_q && !wr_take) begin
                err_d = 1'b1;
            end else begin
                wr_pend_d = 1'b1;
                wr_addr_d = i_waddr;
                wr_data_d = i_wdata;
            end
        end
    end

    // Decoded from the state register so reset drops them asynchronously.
    assign o_mem_req        = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign o_mem_wen        = (state_q == WR_REQ);
    assign o_mem_addr       = cur_addr_q;
    assign o_mem_wdata      = cur_wdata_q;
    assign o_read_complete  = (state_q == RD_DONE);
    assign o_write_complete = (state_q == WR_DONE);
    assign o_rdata          = rdata_q;
    assign o_err            = err_q;
    assign o_busy           = (state_q != IDLE) || rd_pend_q || wr_pend_q;

endmodule

// File: tb/tb_mcu_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mcu_mem_responder
//
// Scoreboard bench: each request pushes its expected completion (kind, read
// data, completion cycle) and its expected memory-port operation. A memory
// model acks requests with a per-operation delay and checks the port fields;
// a monitor pops completions and checks data and latency.
// ---------------------------------------------------------------------------
module tb_mcu_mem_responder;

    logic        clk;
    logic        n_rst;
    logic        i_re;
    logic [31:0] i_raddr;
    logic        i_we;
    logic [31:0] i_waddr;
    logic [31:0] i_wdata;
    logic        o_read_complete;
    logic [31:0] o_rdata;
    logic        o_write_complete;
    logic        o_err;
    logic        o_busy;
    logic [31:0] o_mem_addr;
    logic        o_mem_req;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    mcu_mem_responder dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .i_re             (i_re),
        .i_raddr          (i_raddr),
        .i_we             (i_we),
        .i_waddr          (i_waddr),
        .i_wdata          (i_wdata),
        .o_read_complete  (o_read_complete),
        .o_rdata          (o_rdata),
        .o_write_complete (o_write_complete),
        .o_err            (o_err),
        .o_busy           (o_busy),
        .o_mem_addr       (o_mem_addr),
        .o_mem_req        (o_mem_req),
        .o_mem_wen        (o_mem_wen),
        .o_mem_wdata      (o_mem_wdata),
        .i_mem_ack        (i_mem_ack),
        .i_mem_rdata      (i_mem_rdata)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] rdata;
        int          exp_cyc;   // -1: latency not checked
    } cmp_t;

    typedef struct {
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;     // request cycles before ack
    } mop_t;

    cmp_t exp_q[$];
    mop_t mem_q[$];

    int n_vec     = 0;
    int n_err     = 0;
    int cyc       = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    bit ack_en    = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void push_exp(input bit is_wr, input logic [31:0] rdata, input int exp_cyc);
        cmp_t e;
        e.is_wr   = is_wr;
        e.rdata   = rdata;
        e.exp_cyc = exp_cyc;
        exp_q.push_back(e);
    endfunction

    function automatic void push_mem(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [31:0] rdata, input int delay);
        mop_t m;
        m.wen   = wen;
        m.addr  = addr;
        m.wdata = wdata;
        m.rdata = rdata;
        m.delay = delay;
        mem_q.push_back(m);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory model: acks the head operation after its delay, checks port fields.
    initial begin
        int  wait_cnt;
        bit  mflag;
        mop_t m;
        wait_cnt    = 0;
        mflag       = 1'b0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(negedge clk);
            i_mem_ack = 1'b0;
            if (o_mem_req && ack_en) begin
                if (mem_q.size() == 0) begin
                    if (!mflag) chk("mem_unexp_req", o_mem_req, 1'b0);
                    mflag = 1'b1;
                end else if (wait_cnt == mem_q[0].delay) begin
                    m = mem_q.pop_front();
                    chk("mem_wen", o_mem_wen, m.wen);
                    chk("mem_addr", o_mem_addr, m.addr);
                    if (m.wen) chk("mem_wdata", o_mem_wdata, m.wdata);
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = m.rdata;
                    wait_cnt    = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                mflag    = 1'b0;
            end
        end
    end

    // Completion monitor: one line per finished transaction.
    initial begin
        cmp_t e;
        forever begin
            @(negedge clk);
            if (o_read_complete) rd_pulses++;
            if (o_write_complete) wr_pulses++;
            if (o_read_complete || o_write_complete) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_complete", {30'b0, o_write_complete, o_read_complete}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_kind", o_write_complete, e.is_wr);
                    if (!e.is_wr) chk("rdata", o_rdata, e.rdata);
                    if (e.exp_cyc >= 0) chk("latency", cyc, e.exp_cyc);
                    $display("cycle %0d: %s complete rdata=0x%0h err=%0b",
                             cyc, o_write_complete ? "write" : "read", o_rdata, o_err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input bit re, input logic [31:0] ra, input bit we,
                         input logic [31:0] wa, input logic [31:0] wd);
        i_re    = re;
        i_raddr = ra;
        i_we    = we;
        i_waddr = wa;
        i_wdata = wd;
        @(negedge clk);
        i_re = 1'b0;
        i_we = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (n < max && (o_busy || exp_q.size() != 0)) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) begin
            chk("idle_wait_busy", o_busy, 1'b0);
            chk("idle_wait_pending", exp_q.size(), 0);
        end
    endtask

    task automatic wait_req(input int max);
        int n;
        n = 0;
        while (n < max && !o_mem_req) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) chk("req_wait", o_mem_req, 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        mem_q.delete();
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int rd_before;
        int wr_before;
        n_rst   = 1'b0;
        i_re    = 1'b0;
        i_raddr = '0;
        i_we    = 1'b0;
        i_waddr = '0;
        i_wdata = '0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_err", o_err, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_mem_req", o_mem_req, 1'b0);
        chk("rst_rd_done", o_read_complete, 1'b0);
        chk("rst_wr_done", o_write_complete, 1'b0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);

        // Single read, ack 3 cycles after request rises
        push_mem(1'b0, 32'h10, 32'h0, 32'hA5A5, 3);
        push_exp(1'b0, 32'hA5A5, cyc + 6);
        drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
        wait_idle(50);
        chk("single_err", o_err, 1'b0);

        // Simultaneous read and write, immediate ack; read first
        wr_before = wr_pulses;
        rd_before = rd_pulses;
        push_mem(1'b0, 32'h20, 32'h0, 32'h1234, 0);
        push_mem(1'b1, 32'd400000, 32'h7F, 32'h0, 0);
        push_exp(1'b0, 32'h1234, cyc + 3);
        push_exp(1'b1, 32'h0, cyc + 6);
        drive(1'b1, 32'h20, 1'b1, 32'd400000, 32'h7F);
        wait_idle(50);
        chk("simul_wr_pulses", wr_pulses - wr_before, 1);
        chk("simul_rd_pulses", rd_pulses - rd_before, 1);
        chk("rdata_hold", o_rdata, 32'h1234);
        chk("simul_err", o_err, 1'b0);

        // Last legal address
        push_mem(1'b0, 32'd759999, 32'h0, 32'hCAFE, 1);
        push_exp(1'b0, 32'hCAFE, cyc + 4);
        drive(1'b1, 32'd759999, 1'b0, 32'h0, 32'h0);
        wait_idle(50);
        chk("edge_ok_err", o_err, 1'b0);

        // First illegal address: read then write, no memory access
        push_exp(1'b0, 32'h0, cyc + 2);
        drive(1'b1, 32'd760000, 1'b0, 32'h0, 32'h0);
        wait_idle(50);
        chk("oor_rdata", o_rdata, 32'd0);
        chk("oor_err", o_err, 1'b1);
        push_exp(1'b1, 32'h0, cyc + 2);
        drive(1'b0, 32'h0, 1'b1, 32'd760001, 32'h55);
        wait_idle(50);

        // Reset in the middle of a read request
        ack_en = 1'b0;
        drive(1'b1, 32'h30, 1'b0, 32'h0, 32'h0);
        wait_req(10);
        #2 n_rst = 1'b0;
        #1;
        chk("async_mem_req", o_mem_req, 1'b0);
        chk("async_busy", o_busy, 1'b0);
        chk("async_err_clr", o_err, 1'b0);
        repeat (2) @(negedge clk);
        n_rst  = 1'b1;
        ack_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", o_busy, 1'b0);
        push_mem(1'b0, 32'h34, 32'h0, 32'h600D, 0);
        push_exp(1'b0, 32'h600D, cyc + 3);
        drive(1'b1, 32'h34, 1'b0, 32'h0, 32'h0);
        wait_idle(50);

        // Timeout: no ack for TIMEOUT request cycles
        ack_en = 1'b0;
        push_exp(1'b0, 32'h0, cyc + 257);
        drive(1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
        wait_idle(400);
        chk("to_rdata", o_rdata, 32'd0);
        chk("to_err", o_err, 1'b1);
        ack_en = 1'b1;
        push_mem(1'b0, 32'h44, 32'h0, 32'hBEEF, 2);
        push_exp(1'b0, 32'hBEEF, cyc + 5);
        drive(1'b1, 32'h44, 1'b0, 32'h0, 32'h0);
        wait_idle(50);

        // Overflow: third read arrives while slot holds a pending read
        apply_reset();
        chk("ovf_err_pre", o_err, 1'b0);
        rd_before = rd_pulses;
        push_mem(1'b0, 32'h100, 32'h0, 32'h1111, 4);
        push_exp(1'b0, 32'h1111, -1);
        drive(1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
        wait_req(10);
        push_mem(1'b0, 32'h104, 32'h0, 32'h2222, 0);
        push_exp(1'b0, 32'h2222, -1);
        drive(1'b1, 32'h104, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'h108, 1'b0, 32'h0, 32'h0);
        wait_idle(60);
        repeat (3) @(negedge clk);
        chk("ovf_rd_pulses", rd_pulses - rd_before, 2);
        chk("ovf_err", o_err, 1'b1);
        chk("ovf_mem_left", mem_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mcu_mem_responder.md
Name: mcu_mem_responder

Overview:
- Memory-side responder for the main control unit's read/write request interface.
- Accepts single-cycle read-enable and write-enable pulses with 32-bit addresses and runs each as one transaction on an ack-handshaked external memory port.
- Returns single-cycle read-complete and write-complete pulses and read data to the control unit.
- Sits between the control unit and the image SRAM/bus; buffers one pending request of each type while busy.

Parameters:
- ADDR_W, 32, address width of both the request interface and the memory interface.
- DATA_W, 32, data width of read and write data.
- MEM_BASE, 0, lowest legal address.
- MEM_LIMIT, 760000, first illegal address; legal range is MEM_BASE <= addr < MEM_LIMIT.
- TIMEOUT, 255, maximum number of cycles to wait for i_mem_ack before aborting; 8-bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- i_re  in  1  read request pulse from the control unit.
- i_raddr  in  ADDR_W  read address, sampled when i_re=1.
- i_we  in  1  write request pulse from the control unit.
- i_waddr  in  ADDR_W  write address, sampled when i_we=1.
- i_wdata  in  DATA_W  write data, sampled when i_we=1.
- o_read_complete  out  1  one-cycle pulse; o_rdata is valid in the same cycle.
- o_rdata  out  DATA_W  read data; holds its value until the next read completes.
- o_write_complete  out  1  one-cycle pulse when a write finishes.
- o_err  out  1  sticky error: address out of range, timeout, or request overflow.
- o_busy  out  1  high when the FSM is not in IDLE or any request is pending.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_req  out  1  memory request; held high until ack.
- o_mem_wen  out  1  1 = write, 0 = read; valid while o_mem_req=1.
- o_mem_wdata  out  DATA_W  memory write data.
- i_mem_ack  in  1  memory acknowledge, one cycle; i_mem_rdata is valid in the same cycle.
- i_mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; both pending slots empty; timeout counter 0.
- Request capture: i_re=1 on an edge loads the read slot (rd_pend=1, address). i_we=1 loads the write slot (wr_pend=1, address, data).
- Both pulses may arrive on the same edge; each goes to its own slot.
- A pulse that arrives while its slot is full is dropped and sets o_err.
- A slot frees on the edge where its transaction leaves IDLE, so a new pulse can arrive on that same edge without overflow.
- State machine: IDLE, RD_REQ, RD_DONE, WR_REQ, WR_DONE.
- IDLE arbitration: if rd_pend, go to RD_REQ; else if wr_pend, go to WR_REQ.
  - Read has priority when both slots are pending, because the control unit stalls on reads.
  - A request captured on edge N is evaluated by IDLE in cycle N+1 (registered, no bypass).
- Range check in IDLE: an out-of-range address skips the memory port entirely.
  - Go directly to RD_DONE/WR_DONE with o_err set.
  - For a read, o_rdata is set to 0.
- RD_REQ / WR_REQ:
  - o_mem_req=1; o_mem_addr and o_mem_wdata come from the slot; o_mem_wen=1 only in WR_REQ.
  - The timeout counter increments every cycle.
  - If i_mem_ack=1: capture i_mem_rdata into o_rdata (reads only) and go to *_DONE.
  - If the counter reaches TIMEOUT without ack: set o_err, set o_rdata=0 for reads, go to *_DONE.
  - The counter clears on leaving the state.
- RD_DONE: o_read_complete=1 for exactly one cycle, then IDLE. WR_DONE: o_write_complete=1 for exactly one cycle, then IDLE.
- Latency: with ack in the first request cycle, i_re on edge 0 gives o_mem_req high in cycle 2 and o_read_complete high in cycle 3.
  - Every additional wait cycle adds 1.
  - A queued write behind a read starts 1 cycle after the read's DONE cycle, i.e. IDLE is visited once between transactions.
- A late i_mem_ack received outside RD_REQ/WR_REQ is ignored.
- o_err clears only on reset.
- Reset mid-operation: o_mem_req drops asynchronously, pending slots are discarded, and no complete pulse is issued.

Test Plan:
- Single read: i_re with i_raddr=0x10; memory acks 3 cycles after o_mem_req rises with rdata=0xA5A5 -> o_read_complete is a one-cycle pulse with o_rdata=0xA5A5; o_mem_wen=0 throughout; o_err=0.
- Simultaneous i_re=1 and i_we=1 (waddr=400000, wdata=0x7F) with immediate ack -> read transaction first, then write; o_mem_addr=400000 and o_mem_wdata=0x7F during the write; exactly one pulse on each complete output.
- Out-of-range read: i_raddr=760000 -> o_mem_req never asserts; o_read_complete asserts 2 cycles after the capture edge (the capture edge is 0, IDLE is cycle 1, RD_DONE is cycle 2); o_rdata=0; o_err=1.
- Timeout: read with i_mem_ack held low -> o_read_complete after TIMEOUT=255 request cycles; o_rdata=0; o_err=1; the FSM then returns to IDLE and serves the next request normally.
- Overflow: i_re, then a second i_re while the first is still in RD_REQ and the slot is already refilled by a pending read -> the third read is dropped; o_err=1; exactly two o_read_complete pulses.
- Reset mid-transaction: drive n_rst low during RD_REQ -> o_mem_req=0 immediately; after release, o_busy=0, no complete pulse is issued, and a fresh read completes normally.
